// File: rtl/ifu_bht_bpu_pkg.sv
// Shared types and constants for the IFU branch-history-table predictor.
// Holds FSM state encodings, 2-bit counter values and the index-width helper.
package ifu_bht_bpu_pkg;

  typedef enum logic [1:0] {
    BPU_IDLE     = 2'd0,
    BPU_WAIT_DEP = 2'd1,
    BPU_RD       = 2'd2,
    BPU_RDY      = 2'd3
  } bpu_state_e;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ifu_bht_bpu_if.sv
// IFU <-> BPU signal bundle: decode info, regfile/pipeline status, resolution
// updates and the prediction outputs. The IFU side is master, the BPU is slave.
interface ifu_bht_bpu_if #(
  parameter int PC_SIZE = 32,
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
);
  logic               dec_i_valid;
  logic [PC_SIZE-1:0] pc;
  logic               dec_jal;
  logic               dec_jalr;
  logic               dec_bxx;
  logic [XLEN-1:0]    dec_bjp_imm;
  logic [RFIDX_W-1:0] dec_jalr_rs1idx;
  logic               oitf_empty;
  logic               ir_empty;
  logic               jalr_rs1idx_cam_irrdidx;
  logic [XLEN-1:0]    rf2bpu_x1;
  logic [XLEN-1:0]    rf2bpu_rs1;
  logic               flush;
  logic               upd_valid;
  logic [PC_SIZE-1:0] upd_pc;
  logic               upd_taken;
  logic               prdt_taken;
  logic [PC_SIZE-1:0] prdt_pc_add_op1;
  logic [PC_SIZE-1:0] prdt_pc_add_op2;
  logic               bpu_wait;
  logic               bpu2rf_rs1_ena;

  modport master (
    output dec_i_valid, pc, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm, dec_jalr_rs1idx,
           oitf_empty, ir_empty, jalr_rs1idx_cam_irrdidx, rf2bpu_x1, rf2bpu_rs1,
           flush, upd_valid, upd_pc, upd_taken,
    input  prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2, bpu_wait, bpu2rf_rs1_ena
  );

  modport slave (
    input  dec_i_valid, pc, dec_jal, dec_jalr, dec_bxx, dec_bjp_imm, dec_jalr_rs1idx,
           oitf_empty, ir_empty, jalr_rs1idx_cam_irrdidx, rf2bpu_x1, rf2bpu_rs1,
           flush, upd_valid, upd_pc, upd_taken,
    output prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2, bpu_wait, bpu2rf_rs1_ena
  );

endinterface

// File: rtl/ifu_bht_cnt_array.sv
// Table of 2-bit saturating direction counters with one asynchronous read
// port and one clocked update port. Reads see the pre-update value.
module ifu_bht_cnt_array
  import ifu_bht_bpu_pkg::*;
#(
  parameter int         DEPTH    = 64,
  parameter int         IDX_W    = clog2(DEPTH),
  parameter logic [1:0] CNT_INIT = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt [DEPTH];

  assign rd_cnt = cnt[rd_idx];

  // Saturating at both ends: a strongly-biased branch stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= CNT_INIT;
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (cnt[upd_idx] != ST) cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
      end else begin
        if (cnt[upd_idx] != SNT) cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/ifu_bht_bpu.sv
// IFU branch predictor: PC-indexed counter table for conditional branches and
// a registered rs1-read state machine for JALR through a general register.
module ifu_bht_bpu
  import ifu_bht_bpu_pkg::*;
#(
  parameter int         PC_SIZE     = 32,
  parameter int         XLEN        = 32,
  parameter int         RFIDX_W     = 5,
  parameter int         BHT_DEPTH   = 64,
  parameter int         BHT_IDX_LSB = 2,
  parameter logic [1:0] CNT_INIT    = WNT
) (
  input  logic          clk,
  input  logic          rst,
  ifu_bht_bpu_if.slave  bus
);

  localparam int IDX_W = clog2(BHT_DEPTH);

  bpu_state_e         state;
  bpu_state_e         state_nxt;
  logic [XLEN-1:0]    rs1_capture;
  logic               hold;
  logic [PC_SIZE-1:0] hold_pc;
  logic [1:0]         rd_cnt;
  logic               rs1_is_x0;
  logic               rs1_is_x1;
  logic               jalr_xn;
  logic               held;
  logic               dep1;

  ifu_bht_cnt_array #(
    .DEPTH    (BHT_DEPTH),
    .IDX_W    (IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_cnt_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.pc[BHT_IDX_LSB +: IDX_W]),
    .rd_cnt    (rd_cnt),
    .upd_valid (bus.upd_valid),
    .upd_idx   (bus.upd_pc[BHT_IDX_LSB +: IDX_W]),
    .upd_taken (bus.upd_taken)
  );

  assign rs1_is_x0 = (bus.dec_jalr_rs1idx == RFIDX_W'(0));
  assign rs1_is_x1 = (bus.dec_jalr_rs1idx == RFIDX_W'(1));
  assign jalr_xn   = bus.dec_i_valid & bus.dec_jalr & ~rs1_is_x0 & ~rs1_is_x1;
  // The JALR whose rs1 was just captured must not restart the read sequence.
  assign held      = hold & (bus.pc == hold_pc);
  assign dep1      = bus.dec_i_valid & bus.dec_jalr & rs1_is_x1
                   & (~bus.oitf_empty | bus.jalr_rs1idx_cam_irrdidx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BPU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BPU_IDLE: begin
        if (jalr_xn & ~held)
          state_nxt = (~bus.oitf_empty | ~bus.ir_empty) ? BPU_WAIT_DEP : BPU_RD;
      end
      BPU_WAIT_DEP: begin
        if (~bus.dec_i_valid)                  state_nxt = BPU_IDLE;
        else if (bus.oitf_empty & bus.ir_empty) state_nxt = BPU_RD;
      end
      BPU_RD:  state_nxt = BPU_RDY;
      BPU_RDY: state_nxt = BPU_IDLE;
      default: state_nxt = BPU_IDLE;
    endcase
    if (bus.flush) state_nxt = BPU_IDLE;
  end

  always_comb begin
    bus.bpu2rf_rs1_ena = (state == BPU_RD) & ~bus.flush;
    bus.bpu_wait       = dep1 | (state != BPU_IDLE) | (jalr_xn & ~held);
  end

  // Regfile read data arrives the cycle after the enable, i.e. during RDY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                rs1_capture <= '0;
    else if ((state == BPU_RDY) & ~bus.flush) rs1_capture <= bus.rf2bpu_rs1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= 1'b0;
      hold_pc <= '0;
    end else if (bus.flush) begin
      hold    <= 1'b0;
    end else if (state == BPU_RDY) begin
      hold    <= 1'b1;
      hold_pc <= bus.pc;
    end else if (hold & (~bus.dec_i_valid | (bus.pc != hold_pc))) begin
      hold    <= 1'b0;
    end
  end

  always_comb begin
    bus.prdt_taken      = bus.dec_i_valid
                        & (bus.dec_jal | bus.dec_jalr | (bus.dec_bxx & rd_cnt[1]));
    bus.prdt_pc_add_op1 = '0;
    bus.prdt_pc_add_op2 = '0;
    if (bus.dec_i_valid) begin
      bus.prdt_pc_add_op2 = PC_SIZE'($signed(bus.dec_bjp_imm));
      if (bus.dec_jalr) begin
        if (rs1_is_x0)      bus.prdt_pc_add_op1 = '0;
        else if (rs1_is_x1) bus.prdt_pc_add_op1 = PC_SIZE'(bus.rf2bpu_x1);
        else                bus.prdt_pc_add_op1 = PC_SIZE'(rs1_capture);
      end else begin
        bus.prdt_pc_add_op1 = bus.pc;
      end
    end
  end

endmodule

// File: tb/tb_ifu_bht_bpu.sv
// Directed self-checking bench for ifu_bht_bpu: counter training/saturation,
// same-cycle read/update ordering, JALR x0/x1/xN paths, flush and async reset.
module tb_ifu_bht_bpu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ifu_bht_bpu_if #(.PC_SIZE(32), .XLEN(32), .RFIDX_W(5)) bus ();

  ifu_bht_bpu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic jal, input logic jalr,
                               input logic bxx, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [4:0] rs1idx);
    bus.dec_i_valid     = valid;
    bus.dec_jal         = jal;
    bus.dec_jalr        = jalr;
    bus.dec_bxx         = bxx;
    bus.pc              = pc;
    bus.dec_bjp_imm     = imm;
    bus.dec_jalr_rs1idx = rs1idx;
    #1;
  endtask

  task automatic applyUpdate(input logic valid, input logic [31:0] pc, input logic taken);
    bus.upd_valid = valid;
    bus.upd_pc    = pc;
    bus.upd_taken = taken;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    bus.oitf_empty              = 1'b1;
    bus.ir_empty                = 1'b1;
    bus.jalr_rs1idx_cam_irrdidx = 1'b0;
    bus.rf2bpu_x1               = '0;
    bus.rf2bpu_rs1              = '0;
    bus.flush                   = 1'b0;
    applyUpdate(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    checkOutput("rst_taken", 32'(bus.prdt_taken), 32'd0);
    checkOutput("rst_wait",  32'(bus.bpu_wait), 32'd0);
    checkOutput("rst_ena",   32'(bus.bpu2rf_rs1_ena), 32'd0);
    checkOutput("rst_op1",   bus.prdt_pc_add_op1, 32'h0);
    checkOutput("rst_op2",   bus.prdt_pc_add_op2, 32'h0);
    rst = 1'b0;
    tick();

    // Bxx at 0x100 (idx 0): cold counter is WNT, one taken update makes it WT
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFF8, 5'd0);
    applyUpdate(1'b1, 32'h100, 1'b1);
    checkOutput("bxx_cold_taken", 32'(bus.prdt_taken), 32'd0);
    tick();
    applyUpdate(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("bxx_warm_taken", 32'(bus.prdt_taken), 32'd1);
    checkOutput("bxx_op1", bus.prdt_pc_add_op1, 32'h100);
    checkOutput("bxx_op2", bus.prdt_pc_add_op2, 32'hFFFF_FFF8);
    checkOutput("bxx_wait", 32'(bus.bpu_wait), 32'd0);

    // idx 5 (pc 0x14): saturate high, walk down, saturate low
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 32'h10, 5'd0);
    applyUpdate(1'b1, 32'h14, 1'b1);
    repeat (4) tick();
    applyUpdate(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("sat_hi_taken", 32'(bus.prdt_taken), 32'd1);
    applyUpdate(1'b1, 32'h14, 1'b0);
    tick();
    checkOutput("nt1_taken", 32'(bus.prdt_taken), 32'd1);
    tick();
    checkOutput("nt2_taken", 32'(bus.prdt_taken), 32'd0);
    tick();
    checkOutput("nt3_taken", 32'(bus.prdt_taken), 32'd0);
    tick();
    applyUpdate(1'b1, 32'h14, 1'b1);
    tick();
    applyUpdate(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("sat_lo_taken", 32'(bus.prdt_taken), 32'd0);
    applyUpdate(1'b1, 32'h14, 1'b1);
    tick();
    applyUpdate(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("cnt2_taken", 32'(bus.prdt_taken), 32'd1);

    // Same-cycle lookup/update at a WT counter: lookup sees old value
    applyUpdate(1'b1, 32'h14, 1'b0);
    #1;
    checkOutput("same_cycle_old", 32'(bus.prdt_taken), 32'd1);
    tick();
    applyUpdate(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("same_cycle_new", 32'(bus.prdt_taken), 32'd0);

    // JALR x5, no dependency: IDLE, RD, RDY stall then prediction
    bus.rf2bpu_rs1 = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h4, 5'd5);
    checkOutput("x5_c1_wait", 32'(bus.bpu_wait), 32'd1);
    checkOutput("x5_c1_ena",  32'(bus.bpu2rf_rs1_ena), 32'd0);
    tick();
    checkOutput("x5_c2_wait", 32'(bus.bpu_wait), 32'd1);
    checkOutput("x5_c2_ena",  32'(bus.bpu2rf_rs1_ena), 32'd1);
    tick();
    bus.rf2bpu_rs1 = 32'h2000;
    #1;
    checkOutput("x5_c3_wait", 32'(bus.bpu_wait), 32'd1);
    checkOutput("x5_c3_ena",  32'(bus.bpu2rf_rs1_ena), 32'd0);
    tick();
    bus.rf2bpu_rs1 = 32'hDEAD_BEEF;
    #1;
    checkOutput("x5_c4_wait",  32'(bus.bpu_wait), 32'd0);
    checkOutput("x5_c4_op1",   bus.prdt_pc_add_op1, 32'h2000);
    checkOutput("x5_c4_op2",   bus.prdt_pc_add_op2, 32'h4);
    checkOutput("x5_c4_taken", 32'(bus.prdt_taken), 32'd1);
    checkOutput("x5_c4_ena",   32'(bus.bpu2rf_rs1_ena), 32'd0);
    tick();
    checkOutput("x5_held_wait", 32'(bus.bpu_wait), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();

    // JALR x1 with a CAM hit for two cycles
    bus.rf2bpu_x1 = 32'h3000;
    bus.jalr_rs1idx_cam_irrdidx = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h8, 5'd1);
    checkOutput("x1_c1_wait", 32'(bus.bpu_wait), 32'd1);
    checkOutput("x1_c1_ena",  32'(bus.bpu2rf_rs1_ena), 32'd0);
    tick();
    checkOutput("x1_c2_wait", 32'(bus.bpu_wait), 32'd1);
    tick();
    bus.jalr_rs1idx_cam_irrdidx = 1'b0;
    #1;
    checkOutput("x1_c3_wait",  32'(bus.bpu_wait), 32'd0);
    checkOutput("x1_c3_op1",   bus.prdt_pc_add_op1, 32'h3000);
    checkOutput("x1_c3_ena",   32'(bus.bpu2rf_rs1_ena), 32'd0);
    checkOutput("x1_c3_taken", 32'(bus.prdt_taken), 32'd1);

    // JALR x0
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h304, 32'h40, 5'd0);
    checkOutput("x0_op1",  bus.prdt_pc_add_op1, 32'h0);
    checkOutput("x0_op2",  bus.prdt_pc_add_op2, 32'h40);
    checkOutput("x0_wait", 32'(bus.bpu_wait), 32'd0);
    tick();

    // JALR x7 waiting on OITF, flushed out of WAIT_DEP
    bus.oitf_empty = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h10, 5'd7);
    checkOutput("x7_c1_wait", 32'(bus.bpu_wait), 32'd1);
    tick();
    bus.flush = 1'b1;
    #1;
    checkOutput("x7_c2_wait", 32'(bus.bpu_wait), 32'd1);
    checkOutput("x7_c2_ena",  32'(bus.bpu2rf_rs1_ena), 32'd0);
    tick();
    bus.flush = 1'b0;
    bus.oitf_empty = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checkOutput("x7_c3_wait", 32'(bus.bpu_wait), 32'd0);
    checkOutput("x7_c3_ena",  32'(bus.bpu2rf_rs1_ena), 32'd0);
    tick();
    checkOutput("x7_c4_ena", 32'(bus.bpu2rf_rs1_ena), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 32'h0, 5'd0);
    checkOutput("flush_cnt_idx5", 32'(bus.prdt_taken), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 5'd0);
    checkOutput("flush_cnt_idx0", 32'(bus.prdt_taken), 32'd1);
    tick();

    // Async reset while in RD
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 5'd9);
    tick();
    checkOutput("rd_ena_before_rst", 32'(bus.bpu2rf_rs1_ena), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rd_ena_async_rst", 32'(bus.bpu2rf_rs1_ena), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_wait", 32'(bus.bpu_wait), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 5'd0);
    checkOutput("post_rst_cnt_idx0", 32'(bus.prdt_taken), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
